// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (core / debug-DMA) arbiter in front of a single data memory.
//
// One transaction is in flight at a time. The FSM steps IDLE -> ISSUE -> RESP:
//   IDLE  : a winner is picked and its req_ready is raised combinationally.
//           The request is latched at the clock edge.
//   ISSUE : one registered read or write strobe goes to memory.
//   RESP  : the owner gets an rsp_valid pulse. Reads return mem_rd_dat; writes return 0.
// Peak throughput is one access every three cycles.
//
// Configuration macro: DM_ARB_ROUND_ROBIN_EN
//   defined   : round robin. The pointer moves to the port that did not win,
//               and a tie goes to the port the pointer names.
//   undefined : fixed priority. The core wins every tie.
//
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   c_req_valid/we/addr/wdat         core request in
//   c_req_ready                      core request accepted this cycle
//   c_rsp_valid/c_rsp_rdat           core response strobe / read data
//   d_*                              debug/DMA port, same meaning as the core port
//   mem_addr/mem_wr_dat              registered memory address / write data
//   mem_rd_en/mem_wr_en              registered memory strobes (ISSUE cycle only)
//   mem_rd_dat                       memory read data, valid in the cycle after the strobe
//   busy/grant_d                     FSM not IDLE / current owner is the debug port
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              c_req_valid,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdat,
  output logic              c_req_ready,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdat,
  // debug / DMA port
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdat,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdat,
  // data memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_dat,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rd_dat,
  // status
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
  } req_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;        // 1 = debug port owns the transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_dat_q, mem_wr_dat_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0] c_rdat_q, c_rdat_d;
  logic [DATA_W-1:0] d_rdat_q, d_rdat_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic              ptr_q, ptr_d;            // 0 = core has the tie, 1 = debug has it
`endif

  req_t              c_req, d_req, sel_req;
  logic              gnt_c, gnt_d;
  logic [DATA_W-1:0] rsp_data;

  assign c_req = {c_req_we, c_req_addr, c_req_wdat};
  assign d_req = {d_req_we, d_req_addr, d_req_wdat};

  // Arbitration. A port is granted only in IDLE and only while its own valid is high.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (state_q == IDLE) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      gnt_c = c_req_valid && (!d_req_valid || !ptr_q);
      gnt_d = d_req_valid && (!c_req_valid ||  ptr_q);
`else
      gnt_c = c_req_valid;
      gnt_d = d_req_valid && !c_req_valid;
`endif
    end
  end

  assign sel_req = gnt_d ? d_req : c_req;

  // Writes answer with zero data.
  assign rsp_data = we_q ? '0 : mem_rd_dat;

  // Next-state logic and latched request
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wr_dat_d = mem_wr_dat_q;
    mem_rd_en_d  = 1'b0;
    mem_wr_en_d  = 1'b0;
    c_rdat_d     = c_rdat_q;
    d_rdat_d     = d_rdat_q;
`ifdef DM_ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_c || gnt_d) begin
          owner_d      = gnt_d;
          we_d         = sel_req.we;
          mem_addr_d   = sel_req.addr;
          mem_wr_dat_d = sel_req.wdat;
          // The strobes are registered, so they are high during the ISSUE cycle only.
          mem_rd_en_d  = !sel_req.we;
          mem_wr_en_d  =  sel_req.we;
`ifdef DM_ARB_ROUND_ROBIN_EN
          ptr_d        = gnt_c;
`endif
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        // Keep the returned word so rsp_rdat holds it between pulses.
        if (owner_q) d_rdat_d = rsp_data;
        else         c_rdat_d = rsp_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wr_dat_q <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      c_rdat_q     <= '0;
      d_rdat_q     <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_dat_q <= mem_wr_dat_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      c_rdat_q     <= c_rdat_d;
      d_rdat_q     <= d_rdat_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // ready is a combinational path from valid. It is gated by reset so that it
  // is also 0 while reset is held.
  assign c_req_ready = gnt_c & reset;
  assign d_req_ready = gnt_d & reset;

  // The response pulse is in the RESP cycle. rdat passes the live word through
  // during the pulse and shows the held copy at all other times.
  assign c_rsp_valid = (state_q == RESP) && !owner_q;
  assign d_rsp_valid = (state_q == RESP) &&  owner_q;
  assign c_rsp_rdat  = c_rsp_valid ? rsp_data : c_rdat_q;
  assign d_rsp_rdat  = d_rsp_valid ? rsp_data : d_rdat_q;

  assign mem_addr    = mem_addr_q;
  assign mem_wr_dat  = mem_wr_dat_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;

  assign busy        = (state_q != IDLE);
  assign grant_d     = busy && owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter.
// The bench holds a small behavioural memory that sits on the DUT memory port.
// It also holds a cycle-level reference model of arbitration, latency and the
// response data, which the randomized test uses.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req_valid, c_req_we, c_req_ready, c_rsp_valid;
  logic [31:0] c_req_addr, c_req_wdat, c_rsp_rdat;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdat, d_rsp_rdat;
  logic [31:0] mem_addr, mem_wr_dat, mem_rd_dat;
  logic        mem_rd_en, mem_wr_en, busy, grant_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(rst_n),
    .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_wdat(c_req_wdat), .c_req_ready(c_req_ready), .c_rsp_valid(c_rsp_valid),
    .c_rsp_rdat(c_rsp_rdat),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdat(d_req_wdat), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .d_rsp_rdat(d_rsp_rdat),
    .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_rd_dat(mem_rd_dat),
    .busy(busy), .grant_d(grant_d)
  );

  // Data memory: the read word is registered on the strobe edge.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_dat = '0;
  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_dat;
    else if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_dat;
    if (mem_rd_en)      mem_rd_dat <= mem[mem_addr[7:0]];
  end

  logic [31:0] ref_mem [0:15];

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic idle_inputs();
    c_req_valid = 0; c_req_we = 0; c_req_addr = 0; c_req_wdat = 0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdat = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    c_req_valid = 1'b1; d_req_valid = 1'b1;   // ready must stay low anyway
    #3;
    n_checks++;
    if ({c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, mem_rd_en, mem_wr_en, busy, grant_d} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, mem_rd_en, mem_wr_en, busy, grant_d});
    end
    @(posedge clk); #2;
    n_checks++;
    if ({mem_addr, mem_wr_dat, c_rsp_rdat, d_rsp_rdat} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdat=%h crd=%h drd=%h want all 0",
               mem_addr, mem_wr_dat, c_rsp_rdat, d_rsp_rdat);
    end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_core_read();
    preload(8'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({c_req_ready, d_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL core_rd_ready: got %b want 10", {c_req_ready, d_req_ready});
    end
    @(posedge clk); #1; c_req_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_wr_en, busy} !== 3'b101 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL core_rd_issue: got rd/wr/busy=%b addr=%h want 101 addr=10",
                         {mem_rd_en, mem_wr_en, busy}, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({c_rsp_valid, d_rsp_valid, mem_rd_en} !== 3'b100 || c_rsp_rdat !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL core_rd_rsp: got v=%b rdat=%h want 100 deadbeef",
                         {c_rsp_valid, d_rsp_valid, mem_rd_en}, c_rsp_rdat);
    end
    @(negedge clk);
    n_checks++;
    if ({c_rsp_valid, busy} !== 2'b00 || c_rsp_rdat !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL core_rd_hold: got v/busy=%b rdat=%h want 00 deadbeef",
                         {c_rsp_valid, busy}, c_rsp_rdat);
    end
  endtask

  task automatic test_debug_write();
    @(posedge clk); #1;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h20; d_req_wdat = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if ({c_req_ready, d_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL dbg_wr_ready: got %b want 01", {c_req_ready, d_req_ready});
    end
    @(posedge clk); #1; d_req_valid = 0; d_req_we = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_wr_en, grant_d} !== 3'b011 || mem_addr !== 32'h20 || mem_wr_dat !== 32'h12345678) begin
      n_fail++; $display("FAIL dbg_wr_issue: got rd/wr/gd=%b addr=%h wdat=%h want 011 20 12345678",
                         {mem_rd_en, mem_wr_en, grant_d}, mem_addr, mem_wr_dat);
    end
    @(negedge clk);
    n_checks++;
    if ({d_rsp_valid, c_rsp_valid, mem_wr_en} !== 3'b100 || d_rsp_rdat !== 32'h0) begin
      n_fail++; $display("FAIL dbg_wr_rsp: got v=%b rdat=%h want 100 0",
                         {d_rsp_valid, c_rsp_valid, mem_wr_en}, d_rsp_rdat);
    end
    // read back
    @(posedge clk); #1;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h20;
    @(negedge clk);
    @(posedge clk); #1; d_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_rdat !== 32'h12345678) begin
      n_fail++; $display("FAIL dbg_readback: got v=%b rdat=%h want 1 12345678", d_rsp_valid, d_rsp_rdat);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [7:0] order = '0;
    logic [4:0] exp_order;
    int ng = 0, c_left = 4, d_left = 4;
`ifdef DM_ARB_ROUND_ROBIN_EN
    exp_order = 5'b01010;   // c,d,c,d,c (bit i = grant i, 1 = debug)
`else
    exp_order = 5'b10000;   // c,c,c,c then d once c is gone
`endif
    apply_reset();
    for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
      @(posedge clk); #1;
      c_req_valid = (c_left > 0); c_req_we = 0; c_req_addr = 32'h10;
      d_req_valid = (d_left > 0); d_req_we = 0; d_req_addr = 32'h20;
      @(negedge clk);
      n_checks++;
      if (c_req_ready && d_req_ready) begin
        n_fail++; $display("FAIL tie_one_winner: got both ready want one");
      end
      if (c_req_ready)      begin order[ng] = 1'b0; ng++; c_left--; end
      else if (d_req_ready) begin order[ng] = 1'b1; ng++; d_left--; end
    end
    n_checks++;
    if (ng != 5) begin
      n_fail++; $display("FAIL tie_timeout: got %0d grants want 5", ng);
    end
    n_checks++;
    if (order[4:0] !== exp_order) begin
      n_fail++; $display("FAIL tie_order: got %b want %b", order[4:0], exp_order);
    end
    @(posedge clk); #1; idle_inputs();
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    apply_reset();
    @(posedge clk); #1;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h10;
    @(posedge clk); #1; c_req_valid = 0;
    @(negedge clk);
    n_checks++;
    if (mem_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_issue: got rd_en=%b want 1", mem_rd_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_rd_en, busy} !== 2'b00) begin
      n_fail++; $display("FAIL abort_async: got rd/busy=%b want 00", {mem_rd_en, busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({c_rsp_valid, d_rsp_valid} !== 2'b00) begin
        n_fail++; $display("FAIL abort_no_rsp: got %b want 00", {c_rsp_valid, d_rsp_valid});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b want 0", busy);
    end
    @(posedge clk); #1;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if (c_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_next_ready: got %b want 1", c_req_ready);
    end
    @(posedge clk); #1; c_req_valid = 0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (c_rsp_valid !== 1'b1 || c_rsp_rdat !== 32'h12345678) begin
      n_fail++; $display("FAIL abort_next_rsp: got v=%b rdat=%h want 1 12345678", c_rsp_valid, c_rsp_rdat);
    end
    @(negedge clk);
  endtask

  task automatic test_throughput();
    int acc = 0;
    int at[0:8];
    logic both = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(posedge clk); #1;
      c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h10;
      @(negedge clk);
      if (mem_rd_en && mem_wr_en) both = 1'b1;
      if (c_req_ready) begin at[acc] = cyc; acc++; end
    end
    @(posedge clk); #1; idle_inputs();
    n_checks++;
    if (acc != 3) begin
      n_fail++; $display("FAIL thru_count: got %0d accepts want 3", acc);
    end else begin
      n_checks++;
      if (at[0] != 0 || at[1] != 3 || at[2] != 6) begin
        n_fail++; $display("FAIL thru_spacing: got %0d,%0d,%0d want 0,3,6", at[0], at[1], at[2]);
      end
    end
    n_checks++;
    if (both) begin
      n_fail++; $display("FAIL thru_strobes: got rd and wr high together want never");
    end
    repeat (3) @(posedge clk);
  endtask

  // Random traffic from both ports. A request is held until it is accepted.
  // The model tracks cycles-to-idle, the owner and the expected response word.
  task automatic test_random();
    int          busy_left = 0;
    logic        own = 0, own_we = 0;
    logic [31:0] own_addr = 0, own_wdat = 0, own_rsp = 0;
    logic [31:0] last_c = 0, last_d = 0;
    logic        cv = 0, dv = 0, cwe = 0, dwe = 0;
    logic [31:0] caddr = 0, daddr = 0, cwdat = 0, dwdat = 0;
    logic        gc, gd, erd, ewr, ecv, edv;
`ifdef DM_ARB_ROUND_ROBIN_EN
    logic        ptr = 0;
`endif
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      preload(a[7:0], ref_mem[a]);
    end
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (!cv && $urandom_range(0, 99) < 55) begin
        cv = 1; cwe = 1'($urandom_range(0, 1)); caddr = $urandom_range(0, 15); cwdat = $urandom;
      end
      if (!dv && $urandom_range(0, 99) < 55) begin
        dv = 1; dwe = 1'($urandom_range(0, 1)); daddr = $urandom_range(0, 15); dwdat = $urandom;
      end
      c_req_valid = cv; c_req_we = cwe; c_req_addr = caddr; c_req_wdat = cwdat;
      d_req_valid = dv; d_req_we = dwe; d_req_addr = daddr; d_req_wdat = dwdat;
      @(negedge clk);
      gc = 0; gd = 0;
      if (busy_left == 0) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (cv && dv) begin gd = ptr; gc = !ptr; end
        else begin gc = cv; gd = dv; end
`else
        gc = cv; gd = dv && !cv;
`endif
      end
      erd = (busy_left == 2) && !own_we;
      ewr = (busy_left == 2) &&  own_we;
      ecv = (busy_left == 1) && !own;
      edv = (busy_left == 1) &&  own;
      if (ecv) last_c = own_rsp;
      if (edv) last_d = own_rsp;
      n_checks++;
      if ({c_req_ready, d_req_ready} !== {gc, gd}) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, {c_req_ready, d_req_ready}, {gc, gd});
      end
      n_checks++;
      if ({mem_rd_en, mem_wr_en} !== {erd, ewr} ||
          (busy_left == 2 && (mem_addr !== own_addr || (own_we && mem_wr_dat !== own_wdat)))) begin
        n_fail++; $display("FAIL rnd_mem cyc %0d: got rd/wr=%b addr=%h wdat=%h want %b %h %h",
                           cyc, {mem_rd_en, mem_wr_en}, mem_addr, mem_wr_dat, {erd, ewr}, own_addr, own_wdat);
      end
      n_checks++;
      if ({busy, grant_d} !== {busy_left != 0, busy_left != 0 && own}) begin
        n_fail++; $display("FAIL rnd_status cyc %0d: got busy/gd=%b", cyc, {busy, grant_d});
      end
      n_checks++;
      if ({c_rsp_valid, d_rsp_valid} !== {ecv, edv} || c_rsp_rdat !== last_c || d_rsp_rdat !== last_d) begin
        n_fail++; $display("FAIL rnd_rsp cyc %0d: got v=%b c=%h d=%h want %b %h %h",
                           cyc, {c_rsp_valid, d_rsp_valid}, c_rsp_rdat, d_rsp_rdat, {ecv, edv}, last_c, last_d);
      end
      if (busy_left > 0) busy_left--;
      else if (gc || gd) begin
        own      = gd;
        own_we   = gd ? dwe : cwe;
        own_addr = gd ? daddr : caddr;
        own_wdat = gd ? dwdat : cwdat;
        own_rsp  = own_we ? 32'h0 : ref_mem[own_addr[3:0]];
        if (own_we) ref_mem[own_addr[3:0]] = own_wdat;
`ifdef DM_ARB_ROUND_ROBIN_EN
        ptr = gc;
`endif
        busy_left = 2;
        if (gd) dv = 0; else cv = 0;
      end
    end
    @(posedge clk); #1; idle_inputs();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_debug_write();
    test_tie();
    test_reset_abort();
    test_throughput();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
